// File: rtl/vit_pkg.sv
// Shared Viterbi types and the survivor step rule, used by both the ACS writer and the traceback reader.
// The step rule shifts the decision bit in at the LSB, so the state MSB is the decoded bit.
package vit_pkg;
  localparam int STATE_W = 3;
  localparam int ADDR_W  = 10;
  localparam int MEM_W   = 1 << STATE_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [MEM_W-1:0]   word_t;

  typedef enum logic [1:0] {
    TB_IDLE,
    TB_FETCH,
    TB_DRAIN,
    TB_FINISH
  } tb_state_e;

  function automatic state_t tb_step(input state_t s, input word_t w);
    tb_step = {s[STATE_W-2:0], w[s]};
  endfunction
endpackage

// File: rtl/traceback_unit_if.sv
// Command, survivor-memory read and decoded-bit signals of the traceback unit.
// slave is the traceback unit; master is the controller/memory side driving it.
interface traceback_unit_if;
  import vit_pkg::*;

  logic   start;
  addr_t  start_addr;
  state_t start_state;
  addr_t  tb_len;
  logic   abort;
  logic   mem_req;
  addr_t  mem_addr;
  word_t  mem_rd_data;
  logic   bit_o;
  logic   bit_valid;
  logic   busy;
  logic   done;
  state_t final_state;

  modport slave (
    input  start, start_addr, start_state, tb_len, abort, mem_rd_data,
    output mem_req, mem_addr, bit_o, bit_valid, busy, done, final_state
  );

  modport master (
    output start, start_addr, start_state, tb_len, abort, mem_rd_data,
    input  mem_req, mem_addr, bit_o, bit_valid, busy, done, final_state
  );
endinterface

// File: rtl/traceback_unit.sv
// Viterbi traceback reader: walks the survivor memory backwards, one decoded bit per clk, newest first.
// Latency 3 cycles start->first bit; no backpressure, start ignored while busy, abort cancels silently.
module traceback_unit
  import vit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  traceback_unit_if.slave io
);

  tb_state_e st_q, st_d;
  addr_t     addr_q, addr_d;
  addr_t     remain_q, remain_d;
  logic      req_q, req_d;
  logic      pend_q, pend_d;
  state_t    cur_q, cur_d;
  logic      bit_q, bit_d;
  logic      bvld_q, bvld_d;
  logic      done_q, done_d;
  state_t    fin_q, fin_d;
  state_t    nxt_state;

  always_comb begin
    st_d      = st_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    req_d     = 1'b0;
    pend_d    = 1'b0;
    cur_d     = cur_q;
    bit_d     = bit_q;
    bvld_d    = 1'b0;
    done_d    = 1'b0;
    fin_d     = fin_q;
    nxt_state = tb_step(cur_q, io.mem_rd_data);

    case (st_q)
      TB_IDLE: begin
        if (io.start) begin
          if (io.tb_len == '0) begin
            st_d   = TB_FINISH;
            done_d = 1'b1;
            fin_d  = io.start_state;
          end else begin
            st_d     = TB_FETCH;
            addr_d   = io.start_addr;
            remain_d = io.tb_len - addr_t'(1);
            req_d    = 1'b1;
            cur_d    = io.start_state;
          end
        end
      end
      TB_FETCH: begin
        pend_d = req_q;
        if (remain_q != '0) begin
          addr_d   = addr_q - addr_t'(1);
          remain_d = remain_q - addr_t'(1);
          req_d    = 1'b1;
        end else begin
          st_d = TB_DRAIN;
        end
      end
      // Only the last fetch is still in flight here, so this cycle emits the final bit.
      TB_DRAIN: begin
        st_d   = TB_FINISH;
        done_d = 1'b1;
        fin_d  = nxt_state;
      end
      TB_FINISH: begin
        st_d = TB_IDLE;
      end
    endcase

    if (pend_q && (st_q == TB_FETCH || st_q == TB_DRAIN)) begin
      bit_d  = cur_q[STATE_W-1];
      bvld_d = 1'b1;
      cur_d  = nxt_state;
    end

    if (io.abort && st_q != TB_IDLE) begin
      st_d   = TB_IDLE;
      req_d  = 1'b0;
      pend_d = 1'b0;
      bvld_d = 1'b0;
      done_d = 1'b0;
      cur_d  = cur_q;
      fin_d  = fin_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= TB_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      req_q    <= 1'b0;
      pend_q   <= 1'b0;
      cur_q    <= '0;
      bit_q    <= 1'b0;
      bvld_q   <= 1'b0;
      done_q   <= 1'b0;
      fin_q    <= '0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      req_q    <= req_d;
      pend_q   <= pend_d;
      cur_q    <= cur_d;
      bit_q    <= bit_d;
      bvld_q   <= bvld_d;
      done_q   <= done_d;
      fin_q    <= fin_d;
    end
  end

  assign io.mem_req     = req_q;
  assign io.mem_addr    = addr_q;
  assign io.bit_o       = bit_q;
  assign io.bit_valid   = bvld_q;
  assign io.busy        = (st_q != TB_IDLE);
  assign io.done        = done_q;
  assign io.final_state = fin_q;

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit with a 1-cycle synchronous survivor memory model.
// Expected addresses, bits and states are hand-derived from the step rule.
module tb_traceback_unit;
  import vit_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  logic [7:0] mem [0:1023];

  traceback_unit_if tbif ();

  traceback_unit dut (
    .clk (clk),
    .rst (rst),
    .io  (tbif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) tbif.mem_rd_data <= mem[tbif.mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic go(input int a, input int s, input int len);
    tbif.start       = 1'b1;
    tbif.start_addr  = addr_t'(a);
    tbif.start_state = state_t'(s);
    tbif.tb_len      = addr_t'(len);
    tick();
    tbif.start = 1'b0;
  endtask

  initial begin
    logic [4:0] seq;
    int nb;
    int nd;
    n_checks = 0;
    n_err    = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst               = 1'b0;
    tbif.start        = 1'b0;
    tbif.start_addr   = '0;
    tbif.start_state  = '0;
    tbif.tb_len       = '0;
    tbif.abort        = 1'b0;
    tbif.mem_rd_data  = '0;
    tick();
    tick();
    chk("rst_mem_req", 32'(tbif.mem_req), 32'd0);
    chk("rst_busy", 32'(tbif.busy), 32'd0);
    chk("rst_final", 32'(tbif.final_state), 32'd0);
    rst = 1'b1;
    tick();

    // Test 1: basic trace
    mem[10] = 8'h20; mem[9] = 8'h00; mem[8] = 8'hFF;
    go(10, 5, 3);                                              // now C1
    chk("t1_addr_c1", 32'(tbif.mem_addr), 32'd10);
    chk("t1_req_c1", 32'(tbif.mem_req), 32'd1);
    chk("t1_busy_c1", 32'(tbif.busy), 32'd1);
    chk("t1_bvld_c1", 32'(tbif.bit_valid), 32'd0);
    tick();
    chk("t1_addr_c2", 32'(tbif.mem_addr), 32'd9);
    tick();
    chk("t1_addr_c3", 32'(tbif.mem_addr), 32'd8);
    chk("t1_bvld_c3", 32'(tbif.bit_valid), 32'd1);
    chk("t1_bit_c3", 32'(tbif.bit_o), 32'd1);
    tick();
    chk("t1_req_c4", 32'(tbif.mem_req), 32'd0);
    chk("t1_bvld_c4", 32'(tbif.bit_valid), 32'd1);
    chk("t1_bit_c4", 32'(tbif.bit_o), 32'd0);
    chk("t1_done_c4", 32'(tbif.done), 32'd0);
    tick();
    chk("t1_bit_c5", 32'(tbif.bit_o), 32'd1);
    chk("t1_done_c5", 32'(tbif.done), 32'd1);
    chk("t1_final_c5", 32'(tbif.final_state), 32'd5);
    chk("t1_busy_c5", 32'(tbif.busy), 32'd1);
    tick();
    chk("t1_busy_c6", 32'(tbif.busy), 32'd0);
    chk("t1_done_c6", 32'(tbif.done), 32'd0);
    tick();

    // Test 2: address wrap, bits 1,0,0, final 7
    mem[1] = 8'h10; mem[0] = 8'h02; mem[1023] = 8'h08;
    go(1, 4, 3);
    chk("t2_addr_c1", 32'(tbif.mem_addr), 32'd1);
    tick();
    chk("t2_addr_c2", 32'(tbif.mem_addr), 32'd0);
    tick();
    chk("t2_addr_c3", 32'(tbif.mem_addr), 32'd1023);
    chk("t2_bit_c3", 32'({tbif.bit_valid, tbif.bit_o}), 32'd3);
    tick();
    chk("t2_bit_c4", 32'({tbif.bit_valid, tbif.bit_o}), 32'd2);
    tick();
    chk("t2_bit_c5", 32'({tbif.bit_valid, tbif.bit_o}), 32'd2);
    chk("t2_done_c5", 32'(tbif.done), 32'd1);
    chk("t2_final", 32'(tbif.final_state), 32'd7);
    tick();

    // Test 3: zero length
    go(77, 3, 0);
    chk("t3_done_c1", 32'(tbif.done), 32'd1);
    chk("t3_req_c1", 32'(tbif.mem_req), 32'd0);
    chk("t3_bvld_c1", 32'(tbif.bit_valid), 32'd0);
    chk("t3_busy_c1", 32'(tbif.busy), 32'd1);
    chk("t3_final", 32'(tbif.final_state), 32'd3);
    tick();
    chk("t3_busy_c2", 32'(tbif.busy), 32'd0);
    chk("t3_done_c2", 32'(tbif.done), 32'd0);
    tick();

    // Test 4: start while busy ignored; bits 0,0,0,1,1, final 7
    for (int i = 16; i <= 20; i++) mem[i] = 8'hFF;
    seq = '0; nb = 0; nd = 0;
    go(20, 0, 5);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) tick();
      tbif.start       = (c == 2);
      tbif.start_addr  = addr_t'(100);
      tbif.tb_len      = addr_t'(2);
      tbif.start_state = state_t'(2);
      if (tbif.bit_valid) begin
        seq = {seq[3:0], tbif.bit_o};
        nb++;
      end
      if (tbif.done) nd++;
    end
    tbif.start = 1'b0;
    chk("t4_nbits", 32'(nb), 32'd5);
    chk("t4_ndone", 32'(nd), 32'd1);
    chk("t4_seq", 32'(seq), 32'd3);
    chk("t4_final", 32'(tbif.final_state), 32'd7);
    chk("t4_busy_end", 32'(tbif.busy), 32'd0);
    tick();

    // Test 5: abort in C3 of an 8-step run
    go(50, 1, 8);
    tick();
    tick();
    tbif.abort = 1'b1;                                         // C3
    tick();
    tbif.abort = 1'b0;                                         // C4
    chk("t5_busy_c4", 32'(tbif.busy), 32'd0);
    chk("t5_req_c4", 32'(tbif.mem_req), 32'd0);
    chk("t5_bvld_c4", 32'(tbif.bit_valid), 32'd0);
    chk("t5_final_c4", 32'(tbif.final_state), 32'd7);
    nd = 0; nb = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (tbif.done) nd++;
      if (tbif.bit_valid) nb++;
    end
    chk("t5_no_done", 32'(nd), 32'd0);
    chk("t5_no_bits", 32'(nb), 32'd0);
    mem[5] = 8'h04;
    go(5, 2, 1);
    chk("t5_addr_c1", 32'(tbif.mem_addr), 32'd5);
    tick();
    tick();
    chk("t5_bit_c3", 32'({tbif.bit_valid, tbif.bit_o}), 32'd2);
    chk("t5_done_c3", 32'(tbif.done), 32'd1);
    chk("t5_final_c3", 32'(tbif.final_state), 32'd5);
    tick();

    // Test 6: async reset mid-run, then fresh run with bits 1,0, final 7
    go(200, 6, 4);
    tick();
    tick();
    tick();                                                    // C4
    rst = 1'b0;
    #1;
    chk("t6_rst_req", 32'(tbif.mem_req), 32'd0);
    chk("t6_rst_addr", 32'(tbif.mem_addr), 32'd0);
    chk("t6_rst_bvld", 32'(tbif.bit_valid), 32'd0);
    chk("t6_rst_busy", 32'(tbif.busy), 32'd0);
    chk("t6_rst_bit", 32'(tbif.bit_o), 32'd0);
    chk("t6_rst_final", 32'(tbif.final_state), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    mem[300] = 8'h20; mem[299] = 8'h08;
    go(300, 5, 2);
    chk("t6_addr_c1", 32'(tbif.mem_addr), 32'd300);
    tick();
    tick();
    chk("t6_bit_c3", 32'({tbif.bit_valid, tbif.bit_o}), 32'd3);
    tick();
    chk("t6_bit_c4", 32'({tbif.bit_valid, tbif.bit_o}), 32'd2);
    chk("t6_done_c4", 32'(tbif.done), 32'd1);
    chk("t6_final", 32'(tbif.final_state), 32'd7);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
